// File: rtl/mst_gpio_pkg.sv
// Shared types and default parameters for the board GPIO controller.
package mst_gpio_pkg;

  localparam int unsigned DB_W_DEF    = 16;
  localparam int unsigned RST_CYC_DEF = 16;
  localparam int unsigned OOB_CYC_DEF = 8;
  localparam int unsigned HB_W_DEF    = 24;

  typedef enum logic [1:0] {
    StHold,
    StLoad,
    StRun
  } state_e;

endpackage

// File: rtl/mst_gpio_dbnc.sv
// Two-flop synchronizer followed by a consecutive-cycle debounce filter.
module mst_gpio_dbnc #(
  parameter int unsigned DB_W    = 16,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_db
);

  logic            r_s1;
  logic            r_s2;
  logic            r_db;
  logic [DB_W-1:0] r_cnt;

  // The count covers consecutive cycles of disagreement; the final one flips the output.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1  <= RST_VAL;
      r_s2  <= RST_VAL;
      r_db  <= RST_VAL;
      r_cnt <= '0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      if (r_s2 == r_db) begin
        r_cnt <= '0;
      end else if (&r_cnt) begin
        r_db  <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + DB_W'(1);
      end
    end
  end

  assign o_db = r_db;

endmodule

// File: rtl/mst_gpio_ctl.sv
// Board GPIO controller: soft-reset sequencing, mode latching, OOB pulses, sticky error LEDs.
// Optional heartbeat counter enabled by defining MST_GPIO_HEARTBEAT_EN.
module mst_gpio_ctl
  import mst_gpio_pkg::*;
#(
  parameter int unsigned DB_W    = DB_W_DEF,
  parameter int unsigned RST_CYC = RST_CYC_DEF,
  parameter int unsigned OOB_CYC = OOB_CYC_DEF,
  parameter int unsigned HB_W    = HB_W_DEF
) (
  input  logic       CLK,
  input  logic       HRST_N,
  input  logic       sw_mltcn,
  input  logic       sw_stren,
  input  logic       sw_erdis,
  input  logic       btn_rst_n,
  input  logic       btn_roob,
  input  logic       btn_woob,
  input  logic [3:0] STRER,
  output logic       SRST_N,
  output logic       MLTCN,
  output logic       STREN,
  output logic       ERDIS,
  output logic       R_OOB,
  output logic       W_OOB,
  output logic [3:0] LED,
  output logic       HB
);

  localparam int unsigned RC_W = $clog2(RST_CYC + 1);
  localparam int unsigned OC_W = $clog2(OOB_CYC + 1);
  localparam logic [RC_W-1:0] RST_LAST = RC_W'(RST_CYC - 1);
  localparam logic [OC_W-1:0] OOB_LAST = OC_W'(OOB_CYC - 1);

  logic w_db_mltcn, w_db_stren, w_db_erdis, w_db_rst_n, w_db_roob, w_db_woob;

  mst_gpio_dbnc #(.DB_W(DB_W), .RST_VAL(1'b0)) u_dbnc_mltcn (
    .i_clk(CLK), .i_rst_n(HRST_N), .i_raw(sw_mltcn), .o_db(w_db_mltcn)
  );
  mst_gpio_dbnc #(.DB_W(DB_W), .RST_VAL(1'b0)) u_dbnc_stren (
    .i_clk(CLK), .i_rst_n(HRST_N), .i_raw(sw_stren), .o_db(w_db_stren)
  );
  mst_gpio_dbnc #(.DB_W(DB_W), .RST_VAL(1'b0)) u_dbnc_erdis (
    .i_clk(CLK), .i_rst_n(HRST_N), .i_raw(sw_erdis), .o_db(w_db_erdis)
  );
  mst_gpio_dbnc #(.DB_W(DB_W), .RST_VAL(1'b1)) u_dbnc_rst (
    .i_clk(CLK), .i_rst_n(HRST_N), .i_raw(btn_rst_n), .o_db(w_db_rst_n)
  );
  mst_gpio_dbnc #(.DB_W(DB_W), .RST_VAL(1'b0)) u_dbnc_roob (
    .i_clk(CLK), .i_rst_n(HRST_N), .i_raw(btn_roob), .o_db(w_db_roob)
  );
  mst_gpio_dbnc #(.DB_W(DB_W), .RST_VAL(1'b0)) u_dbnc_woob (
    .i_clk(CLK), .i_rst_n(HRST_N), .i_raw(btn_woob), .o_db(w_db_woob)
  );

  state_e          r_state;
  logic [RC_W-1:0] r_hold_cnt;
  logic [OC_W-1:0] r_rcnt;
  logic [OC_W-1:0] r_wcnt;
  logic            r_srst_n, r_mltcn, r_stren, r_roob, r_woob;
  logic            r_roob_prev, r_woob_prev;
  logic [3:0]      r_led;
  logic            w_leave, w_roob_rise, w_woob_rise;

  assign w_leave     = !w_db_rst_n || (w_db_mltcn != r_mltcn) || (w_db_stren != r_stren);
  assign w_roob_rise = w_db_roob & ~r_roob_prev;
  assign w_woob_rise = w_db_woob & ~r_woob_prev;

  always_ff @(posedge CLK or negedge HRST_N) begin
    if (!HRST_N) begin
      r_state     <= StHold;
      r_hold_cnt  <= '0;
      r_srst_n    <= 1'b0;
      r_mltcn     <= 1'b0;
      r_stren     <= 1'b0;
      r_roob      <= 1'b0;
      r_woob      <= 1'b0;
      r_rcnt      <= '0;
      r_wcnt      <= '0;
      r_led       <= '0;
      r_roob_prev <= 1'b0;
      r_woob_prev <= 1'b0;
    end else begin
      r_roob_prev <= w_db_roob;
      r_woob_prev <= w_db_woob;
      case (r_state)
        StHold: begin
          r_srst_n <= 1'b0;
          r_roob   <= 1'b0;
          r_woob   <= 1'b0;
          r_rcnt   <= '0;
          r_wcnt   <= '0;
          // A held reset button keeps restarting the hold window.
          if (!w_db_rst_n) begin
            r_hold_cnt <= '0;
          end else if (r_hold_cnt == RST_LAST) begin
            r_hold_cnt <= '0;
            r_state    <= StLoad;
          end else begin
            r_hold_cnt <= r_hold_cnt + RC_W'(1);
          end
        end
        StLoad: begin
          r_mltcn  <= w_db_mltcn;
          r_stren  <= w_db_stren;
          r_led    <= '0;
          r_srst_n <= 1'b1;
          r_state  <= StRun;
        end
        StRun: begin
          r_led <= r_led | STRER;
          if (w_leave) begin
            r_state    <= StHold;
            r_hold_cnt <= '0;
            r_srst_n   <= 1'b0;
            r_roob     <= 1'b0;
            r_woob     <= 1'b0;
            r_rcnt     <= '0;
            r_wcnt     <= '0;
          end else begin
            if (r_roob) begin
              if (r_rcnt == '0) r_roob <= 1'b0;
              else              r_rcnt <= r_rcnt - OC_W'(1);
            end else if (w_roob_rise) begin
              r_roob <= 1'b1;
              r_rcnt <= OOB_LAST;
            end
            if (r_woob) begin
              if (r_wcnt == '0) r_woob <= 1'b0;
              else              r_wcnt <= r_wcnt - OC_W'(1);
            end else if (w_woob_rise) begin
              r_woob <= 1'b1;
              r_wcnt <= OOB_LAST;
            end
          end
        end
        default: r_state <= StHold;
      endcase
    end
  end

  assign SRST_N = r_srst_n;
  assign MLTCN  = r_mltcn;
  assign STREN  = r_stren;
  assign ERDIS  = w_db_erdis;
  assign R_OOB  = r_roob;
  assign W_OOB  = r_woob;
  assign LED    = r_led;

`ifdef MST_GPIO_HEARTBEAT_EN
  logic [HB_W-1:0] r_hb_cnt;

  always_ff @(posedge CLK or negedge HRST_N) begin
    if (!HRST_N) r_hb_cnt <= '0;
    else         r_hb_cnt <= r_hb_cnt + HB_W'(1);
  end

  assign HB = r_hb_cnt[HB_W-1];
`else
  logic [HB_W-1:0] w_hb_unused;
  assign w_hb_unused = '0;
  assign HB = 1'b0;
`endif

endmodule

// File: tb/tb_mst_gpio_ctl.sv
// Scoreboard bench for mst_gpio_ctl: cycle model pushes expected outputs, monitor pops and compares.
module tb_mst_gpio_ctl;

  localparam int unsigned DB_W    = 2;
  localparam int unsigned RST_CYC = 4;
  localparam int unsigned OOB_CYC = 3;
  localparam int unsigned DBN     = 1 << DB_W;
  localparam int MHold = 0, MLoad = 1, MRun = 2;

  logic       CLK = 1'b0;
  logic       HRST_N;
  logic       sw_mltcn, sw_stren, sw_erdis, btn_rst_n, btn_roob, btn_woob;
  logic [3:0] STRER;
  logic       SRST_N, MLTCN, STREN, ERDIS, R_OOB, W_OOB, HB;
  logic [3:0] LED;

  always #5 CLK = ~CLK;

  mst_gpio_ctl #(.DB_W(DB_W), .RST_CYC(RST_CYC), .OOB_CYC(OOB_CYC)) dut (
    .CLK(CLK), .HRST_N(HRST_N),
    .sw_mltcn(sw_mltcn), .sw_stren(sw_stren), .sw_erdis(sw_erdis),
    .btn_rst_n(btn_rst_n), .btn_roob(btn_roob), .btn_woob(btn_woob),
    .STRER(STRER),
    .SRST_N(SRST_N), .MLTCN(MLTCN), .STREN(STREN), .ERDIS(ERDIS),
    .R_OOB(R_OOB), .W_OOB(W_OOB), .LED(LED), .HB(HB)
  );

  int tests = 0;
  int fails = 0;
  logic [10:0] exp_q[$];

  // Reference model state; index order: mltcn, stren, erdis, rst_n, roob, woob.
  logic [5:0]     m_s1, m_s2, m_db, m_prev;
  logic [DBN-1:0] m_hist[6];
  int             m_nh[6];
  int             m_mode, m_ok, m_edge, m_rs, m_re, m_ws, m_we;
  logic           m_mltcn, m_stren;
  logic [3:0]     m_led;

  function automatic logic [10:0] out_vec();
    return {SRST_N, MLTCN, STREN, ERDIS, R_OOB, W_OOB, LED, HB};
  endfunction

  task automatic model_reset();
    m_s1 = 6'b001000; m_s2 = 6'b001000; m_db = 6'b001000; m_prev = 6'b001000;
    for (int i = 0; i < 6; i++) begin
      m_hist[i] = '0;
      m_nh[i]   = 0;
    end
    m_mode = MHold; m_ok = 0; m_edge = 0;
    m_rs = 0; m_re = 0; m_ws = 0; m_we = 0;
    m_mltcn = 1'b0; m_stren = 1'b0; m_led = 4'h0;
  endtask

  // Model: reacts to each clock edge (pushing an expectation) and to async reset.
  initial begin
    logic [5:0] d, raw;
    logic       rr, wr;
    model_reset();
    forever begin
      @(posedge CLK or negedge HRST_N);
      if (!HRST_N) begin
        model_reset();
        if (CLK) exp_q.push_back(11'h0);
      end else begin
        m_edge++;
        d   = m_db;
        raw = {btn_woob, btn_roob, btn_rst_n, sw_erdis, sw_stren, sw_mltcn};
        rr  = d[4] & ~m_prev[4];
        wr  = d[5] & ~m_prev[5];
        m_prev = d;
        case (m_mode)
          MHold: begin
            if (!d[3]) m_ok = 0;
            else begin
              m_ok++;
              if (m_ok == int'(RST_CYC)) m_mode = MLoad;
            end
          end
          MLoad: begin
            m_mltcn = d[0];
            m_stren = d[1];
            m_led   = 4'h0;
            m_mode  = MRun;
          end
          default: begin
            m_led = m_led | STRER;
            if (!d[3] || d[0] != m_mltcn || d[1] != m_stren) begin
              m_mode = MHold; m_ok = 0;
              m_rs = m_edge; m_re = m_edge; m_ws = m_edge; m_we = m_edge;
            end else begin
              if (rr && !(m_rs <= m_edge - 1 && m_edge - 1 < m_re)) begin
                m_rs = m_edge; m_re = m_edge + int'(OOB_CYC);
              end
              if (wr && !(m_ws <= m_edge - 1 && m_edge - 1 < m_we)) begin
                m_ws = m_edge; m_we = m_edge + int'(OOB_CYC);
              end
            end
          end
        endcase
        // Debounce: flip once the last DBN synced samples all disagree with the output.
        for (int i = 0; i < 6; i++) begin
          m_hist[i] = {m_hist[i][DBN-2:0], m_s2[i]};
          if (m_nh[i] < int'(DBN)) m_nh[i]++;
          if (m_nh[i] == int'(DBN) && m_hist[i] == {DBN{~m_db[i]}}) m_db[i] = ~m_db[i];
        end
        m_s2 = m_s1;
        m_s1 = raw;
        exp_q.push_back({m_mode == MRun, m_mltcn, m_stren, m_db[2],
                         (m_rs <= m_edge && m_edge < m_re), (m_ws <= m_edge && m_edge < m_we),
                         m_led, 1'b0});
      end
    end
  end

  // Monitor: one expectation per clock period, checked mid-cycle.
  initial begin
    logic [10:0] e, a;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = out_vec();
        tests++;
        if (a !== e) begin
          fails++;
          $display("FAIL outputs t=%0t {SRST_N,MLTCN,STREN,ERDIS,R_OOB,W_OOB,LED,HB} got=%b exp=%b",
                   $time, a, e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
    #1;
  endtask

  initial begin
    logic [5:0] rv;
    int         dur[6];
    bit         seen;
    HRST_N = 1'b0;
    sw_mltcn = 1'b1; sw_stren = 1'b0; sw_erdis = 1'b0;
    btn_rst_n = 1'b1; btn_roob = 1'b0; btn_woob = 1'b0; STRER = 4'h0;
    cycles(3);
    HRST_N = 1'b1;
    cycles(40);

    // Short stren glitch, then a sustained change.
    sw_stren = 1'b1; cycles(2); sw_stren = 1'b0; cycles(10);
    sw_stren = 1'b1; cycles(30);

    // OOB presses: long press, re-press, then both channels together.
    btn_roob = 1'b1; cycles(6); btn_roob = 1'b0; cycles(2);
    btn_roob = 1'b1; cycles(6); btn_roob = 1'b0; cycles(12);
    btn_roob = 1'b1; btn_woob = 1'b1; cycles(8); btn_roob = 1'b0; btn_woob = 1'b0; cycles(12);

    // Sticky error then a held soft-reset button.
    STRER = 4'b0010; cycles(1); STRER = 4'h0; cycles(5);
    btn_rst_n = 1'b0; cycles(10); btn_rst_n = 1'b1; cycles(25);
    sw_erdis = 1'b1; cycles(10);

    rv = {btn_woob, btn_roob, btn_rst_n, sw_erdis, sw_stren, sw_mltcn};
    for (int i = 0; i < 6; i++) dur[i] = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 6; i++) begin
        if (dur[i] == 0) begin
          if (i == 3) begin
            rv[3]  = ($urandom_range(0, 2) != 0);
            dur[3] = rv[3] ? int'($urandom_range(20, 100)) : int'($urandom_range(1, 10));
          end else if (i >= 4) begin
            rv[i]  = 1'($urandom_range(0, 1));
            dur[i] = int'($urandom_range(1, 12));
          end else begin
            rv[i]  = 1'($urandom_range(0, 1));
            dur[i] = int'($urandom_range(5, 150));
          end
        end else begin
          dur[i]--;
        end
      end
      {btn_woob, btn_roob, btn_rst_n, sw_erdis, sw_stren, sw_mltcn} = rv;
      STRER = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'h0;
      cycles(1);
    end

    // Hard reset in the middle of an R_OOB pulse must clear outputs immediately.
    btn_rst_n = 1'b1; btn_roob = 1'b0; btn_woob = 1'b0; STRER = 4'h0;
    cycles(40);
    btn_roob = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      cycles(1);
      seen = (R_OOB === 1'b1);
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL roob_pulse_wait got R_OOB=%b exp=1 within 20 cycles", R_OOB);
    end
    HRST_N = 1'b0;
    #1;
    tests++;
    if (out_vec() !== 11'h0) begin
      fails++;
      $display("FAIL async_reset got=%b exp=%b", out_vec(), 11'h0);
    end
    btn_roob = 1'b0;
    cycles(3);
    HRST_N = 1'b1;
    cycles(30);

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain got=%0d pending exp=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
